uart_rx_frame: RTL and testbench

//  Parametrised UART receiver: configurable data width, parity mode, stop bits and oversampling.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_baud_tick.sv | 38 +++
 rtl/uart_rx_frame.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_rx_frame.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode codes, receiver FSM state encoding and
// a constant-foldable ceil_log2 used to size counters (also used by the TX block).
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Smallest r with 2**r >= value; never returns less than 1 so it can size a vector.
    function automatic int ceil_log2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator.
//   clk, reset   : clock, asynchronous active-low reset
//   en_i         : count while high (receiver busy)
//   restart_i    : synchronous restart of the divider at 0 (start edge)
//   tick_o       : 1-clk pulse every TICK_DIV clocks while enabled
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int TICK_DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic restart_i,
    output logic tick_o
);
    localparam int            CW   = ceil_log2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign tick_o = en_i && !restart_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver with majority-vote sampling and valid/ready output.
//   clk, reset  : clock, asynchronous active-low reset
//   rx_in       : serial line (idle high), asynchronous to clk
//   rx_ready    : consumer accepts the word when rx_valid && rx_ready
//   rx_data     : received word, held while rx_valid
//   rx_valid    : word available
//   parity_err  : parity mismatch of the held word
//   frame_err   : a stop bit of the held word was sampled 0
//   overrun     : sticky, a frame completed while the held word was not accepted
//   break_det   : 1-clk pulse when a whole frame (data, parity, stop) was low
//   busy        : receiver is inside a frame
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int CLK_FREQ    = 50000000,
    parameter int BAUD        = 9600,
    parameter int OVS         = 16,
    parameter int PARITY_MODE = PARITY_NONE,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_in,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 break_det,
    output logic                 busy
);
    localparam int             TICK_DIV = CLK_FREQ / (BAUD * OVS);
    localparam int             BCW      = ceil_log2(DATA_BITS + 1);
    localparam int             OCW      = ceil_log2(OVS);
    localparam logic [OCW-1:0] SMP_LO   = OCW'(OVS / 2 - 1);
    localparam logic [OCW-1:0] SMP_MID  = OCW'(OVS / 2);
    localparam logic [OCW-1:0] SMP_HI   = OCW'(OVS / 2 + 1);
    localparam logic [OCW-1:0] OVS_LAST = OCW'(OVS - 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_BITS - 1);

    logic                 sync1_q, sync2_q, prev_q, armed_q;
    logic [1:0]           warm_q;
    logic [2:0]           state_q, state_d;
    logic [OCW-1:0]       ovs_q, ovs_d;
    logic [BCW-1:0]       bit_q, bit_d;
    logic                 stop_idx_q, stop_idx_d;
    logic [1:0]           smp_q, smp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_acc_q, par_acc_d;
    logic                 fr_acc_q, fr_acc_d;
    logic                 low_q, low_d;
    logic                 tick, start_edge, vote, at_vote, bit_end, last_stop, commit;
    logic                 perr_now, ferr_now, brk_now;

    // Synchroniser and edge history. Reset values of 1 alone would turn a line
    // held low through reset into a falling edge once the flops fill, so start
    // detection is armed only after the synchronised line has been seen high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            warm_q  <= 2'd0;
            armed_q <= 1'b0;
        end else begin
            sync1_q <= rx_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            if (warm_q != 2'd2) warm_q <= warm_q + 2'd1;
            if (warm_q == 2'd2 && sync2_q) armed_q <= 1'b1;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign start_edge = (state_q == ST_IDLE) && armed_q && prev_q && !sync2_q;

    uart_baud_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk       (clk),
        .reset     (reset),
        .en_i      (busy),
        .restart_i (start_edge),
        .tick_o    (tick)
    );

    // Third sample is the live synchronised value on the SMP_HI tick.
    assign vote      = (smp_q[0] & smp_q[1]) | (smp_q[0] & sync2_q) | (smp_q[1] & sync2_q);
    assign at_vote   = tick && (ovs_q == SMP_HI);
    assign bit_end   = tick && (ovs_q == OVS_LAST);
    assign last_stop = (STOP_BITS == 1) || stop_idx_q;

    always_comb begin
        state_d    = state_q;
        ovs_d      = ovs_q;
        bit_d      = bit_q;
        stop_idx_d = stop_idx_q;
        smp_d      = smp_q;
        shift_d    = shift_q;
        par_acc_d  = par_acc_q;
        fr_acc_d   = fr_acc_q;
        low_d      = low_q;
        commit     = 1'b0;

        if (tick) begin
            ovs_d = ovs_q + 1'b1;
            if (ovs_q == SMP_LO)  smp_d[0] = sync2_q;
            if (ovs_q == SMP_MID) smp_d[1] = sync2_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    state_d    = ST_START;
                    ovs_d      = '0;
                    bit_d      = '0;
                    stop_idx_d = 1'b0;
                    par_acc_d  = 1'b0;
                    fr_acc_d   = 1'b0;
                    low_d      = 1'b1;
                end
            end
            ST_START: begin
                if (at_vote && vote) begin
                    state_d = ST_IDLE;          // false start: glitch on the idle line
                end else if (bit_end) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (at_vote) begin
                    shift_d = {vote, shift_q[DATA_BITS-1:1]};   // LSB arrives first
                    if (vote) low_d = 1'b0;
                end
                if (bit_end) begin
                    if (bit_q == BIT_LAST) begin
                        state_d    = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
                        stop_idx_d = 1'b0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (at_vote) begin
                    par_acc_d = (PARITY_MODE == PARITY_EVEN) ? (^shift_q ^ vote)
                                                             : !(^shift_q ^ vote);
                    if (vote) low_d = 1'b0;
                end
                if (bit_end) begin
                    state_d    = ST_STOP;
                    stop_idx_d = 1'b0;
                end
            end
            ST_STOP: begin
                if (at_vote) begin
                    if (!vote) fr_acc_d = 1'b1;
                    if (vote)  low_d    = 1'b0;
                    // Leave at the mid-point so the next start edge is never missed.
                    if (last_stop) begin
                        commit  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (bit_end) begin
                    stop_idx_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            ovs_q      <= '0;
            bit_q      <= '0;
            stop_idx_q <= 1'b0;
            par_acc_q  <= 1'b0;
            fr_acc_q   <= 1'b0;
            low_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ovs_q      <= ovs_d;
            bit_q      <= bit_d;
            stop_idx_q <= stop_idx_d;
            par_acc_q  <= par_acc_d;
            fr_acc_q   <= fr_acc_d;
            low_q      <= low_d;
        end
    end

    // Sample and shift registers are always written before they are read in a frame.
    always_ff @(posedge clk) begin
        smp_q   <= smp_d;
        shift_q <= shift_d;
    end

    assign perr_now = (PARITY_MODE != PARITY_NONE) && par_acc_q;
    assign ferr_now = fr_acc_q | !vote;
    assign brk_now  = low_q & !vote;

    // Output stage: a commit during a same-cycle handshake replaces the word
    // without raising overrun; a commit against an unaccepted word is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            break_det  <= 1'b0;
        end else begin
            break_det <= commit && brk_now;
            if (commit && (!rx_valid || rx_ready)) begin
                rx_data    <= shift_q;
                parity_err <= perr_now;
                frame_err  <= ferr_now;
                rx_valid   <= 1'b1;
                if (rx_valid) overrun <= 1'b0;
            end else if (commit) begin
                overrun <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: three receivers (8N1, 8E1, 8O2) at TICK_DIV=10,
// directed frames plus randomized frames against a frame-level reference model.
module tb_uart_rx_frame;
    localparam int BIT_T = 160;     // OVS * TICK_DIV clocks per bit

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx [3];
    logic       rdy [3];
    logic [7:0] dout [3];
    logic       vld [3], pe [3], fe [3], ovr [3], brk [3], busy [3];

    exp_t       q [3][$];
    logic       ovr_exp [3];
    int         brk_cnt [3];
    int         hs_cnt [3];
    logic [7:0] last_d [3];
    logic       last_pe [3], last_fe [3];
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    uart_rx_frame #(.DATA_BITS(8), .CLK_FREQ(1600000), .BAUD(10000), .OVS(16),
                    .PARITY_MODE(0), .STOP_BITS(1)) u_n1 (
        .clk(clk), .reset(reset), .rx_in(rx[0]), .rx_ready(rdy[0]), .rx_data(dout[0]),
        .rx_valid(vld[0]), .parity_err(pe[0]), .frame_err(fe[0]), .overrun(ovr[0]),
        .break_det(brk[0]), .busy(busy[0]));

    uart_rx_frame #(.DATA_BITS(8), .CLK_FREQ(1600000), .BAUD(10000), .OVS(16),
                    .PARITY_MODE(1), .STOP_BITS(1)) u_e1 (
        .clk(clk), .reset(reset), .rx_in(rx[1]), .rx_ready(rdy[1]), .rx_data(dout[1]),
        .rx_valid(vld[1]), .parity_err(pe[1]), .frame_err(fe[1]), .overrun(ovr[1]),
        .break_det(brk[1]), .busy(busy[1]));

    uart_rx_frame #(.DATA_BITS(8), .CLK_FREQ(1600000), .BAUD(10000), .OVS(16),
                    .PARITY_MODE(2), .STOP_BITS(2)) u_o2 (
        .clk(clk), .reset(reset), .rx_in(rx[2]), .rx_ready(rdy[2]), .rx_data(dout[2]),
        .rx_valid(vld[2]), .parity_err(pe[2]), .frame_err(fe[2]), .overrun(ovr[2]),
        .break_det(brk[2]), .busy(busy[2]));

    function automatic int nstop_of(input int u);
        return (u == 2) ? 2 : 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Inputs change 2 time units after a rising edge; outputs are read on falling edges.
    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Handshake scoreboard: every accepted word must match the oldest expected frame.
    always @(negedge clk) begin
        exp_t e;
        for (int u = 0; u < 3; u++) begin
            if (brk[u]) brk_cnt[u]++;
            if (reset && vld[u] && rdy[u]) begin
                hs_cnt[u]++;
                last_d[u]  = dout[u];
                last_pe[u] = pe[u];
                last_fe[u] = fe[u];
                if (q[u].size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL u%0d unexpected word: got %0h, expected none", u, dout[u]);
                end else begin
                    e = q[u].pop_front();
                    check($sformatf("u%0d data", u), 32'(dout[u]), 32'(e.d));
                    check($sformatf("u%0d parity_err", u), 32'(pe[u]), 32'(e.pe));
                    check($sformatf("u%0d frame_err", u), 32'(fe[u]), 32'(e.fe));
                    check($sformatf("u%0d overrun", u), 32'(ovr[u]), 32'(ovr_exp[u]));
                    ovr_exp[u] = 1'b0;
                end
            end
        end
    end

    // Drive one frame on receiver u; the model derives expected flags from the bits sent.
    task automatic send(input int u, input logic [7:0] d, input logic par,
                        input logic s0, input logic s1, input int gap);
        logic bits [$];
        exp_t e;
        logic exp_brk, drop;
        int   ns, b0;
        ns = nstop_of(u);
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (u != 0) bits.push_back(par);
        bits.push_back(s0);
        if (ns == 2) bits.push_back(s1);

        e.d  = d;
        e.pe = (u == 0) ? 1'b0 : (u == 1) ? (^d ^ par) : !(^d ^ par);
        e.fe = !s0 || (ns == 2 && !s1);
        exp_brk = (d == 8'h00) && (u == 0 || !par) && !s0 && (ns == 1 || !s1);
        drop = !rdy[u] && (q[u].size() != 0);
        if (drop) ovr_exp[u] = 1'b1;
        else      q[u].push_back(e);
        b0 = brk_cnt[u];

        for (int i = 0; i < bits.size(); i++) begin
            rx[u] = bits[i];
            wclk(BIT_T);
        end
        rx[u] = 1'b1;
        check($sformatf("u%0d break pulses", u), 32'(brk_cnt[u] - b0), 32'(exp_brk));
        wclk(gap);
    endtask

    task automatic rand_run(input int u, input int n);
        logic [7:0] d;
        logic       par, s0, s1;
        int         r;
        for (int k = 0; k < n; k++) begin
            r  = $urandom_range(0, 7);
            d  = 8'($urandom);
            par = (u == 2) ? !(^d) : ^d;
            s0 = 1'b1;
            s1 = 1'b1;
            if (r == 0) begin
                d = 8'h00; par = 1'b0; s0 = 1'b0; s1 = 1'b0;
            end else if (r == 1) begin
                par = !par;
            end else if (r == 2 || r == 3) begin
                if (d == 8'h00) d = 8'h01;
                if (r == 2) s0 = 1'b0;
                else        s1 = 1'b0;
            end
            send(u, d, par, s0, s1, $urandom_range(BIT_T, 2 * BIT_T));
        end
    endtask

    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench did not complete");
    end

    initial begin
        int h;
        reset = 1'b0;
        for (int u = 0; u < 3; u++) begin
            rx[u] = 1'b1; rdy[u] = 1'b1; ovr_exp[u] = 1'b0;
            brk_cnt[u] = 0; hs_cnt[u] = 0;
        end
        wclk(5);
        for (int u = 0; u < 3; u++) begin
            check($sformatf("u%0d reset rx_valid", u), 32'(vld[u]), 0);
            check($sformatf("u%0d reset rx_data", u), 32'(dout[u]), 0);
            check($sformatf("u%0d reset errors", u), 32'({pe[u], fe[u], ovr[u], brk[u]}), 0);
            check($sformatf("u%0d reset busy", u), 32'(busy[u]), 0);
        end
        reset = 1'b1;
        wclk(10);

        // 8N1 clean word
        h = hs_cnt[0];
        send(0, 8'hA5, 1'b0, 1'b1, 1'b1, 300);
        check("A5 data", 32'(last_d[0]), 32'h A5);
        check("A5 errors", 32'({last_pe[0], last_fe[0]}), 0);
        check("A5 words", 32'(hs_cnt[0] - h), 1);
        check("A5 valid dropped", 32'(vld[0]), 0);
        check("A5 busy idle", 32'(busy[0]), 0);

        // Framing error and break
        send(0, 8'h55, 1'b0, 1'b0, 1'b1, 300);
        check("55 frame_err", 32'(last_fe[0]), 1);
        send(0, 8'h00, 1'b0, 1'b0, 1'b1, 300);
        check("break data", 32'(last_d[0]), 0);

        // Short low glitch must not produce a word
        h = hs_cnt[0];
        rx[0] = 1'b0;
        wclk(40);
        rx[0] = 1'b1;
        wclk(200);
        check("glitch busy", 32'(busy[0]), 0);
        check("glitch no word", 32'(hs_cnt[0] - h), 0);
        send(0, 8'h3C, 1'b0, 1'b1, 1'b1, 300);
        check("after glitch data", 32'(last_d[0]), 32'h3C);

        // Parity: 0x03 with parity bit 1 is wrong for even, right for odd
        rdy[1] = 1'b0;
        send(1, 8'h03, 1'b1, 1'b1, 1'b1, 100);
        check("even held data", 32'(dout[1]), 32'h03);
        check("even parity_err", 32'(pe[1]), 1);
        rdy[1] = 1'b1;
        wclk(4);
        rdy[2] = 1'b0;
        send(2, 8'h03, 1'b1, 1'b1, 1'b1, 100);
        check("odd held valid", 32'(vld[2]), 1);
        check("odd parity_err", 32'(pe[2]), 0);
        rdy[2] = 1'b1;
        wclk(4);

        // Overrun: second word dropped while the first is held
        rdy[0] = 1'b0;
        send(0, 8'h11, 1'b0, 1'b1, 1'b1, 100);
        send(0, 8'h22, 1'b0, 1'b1, 1'b1, 100);
        check("overrun held data", 32'(dout[0]), 32'h11);
        check("overrun flag", 32'(ovr[0]), 1);
        rdy[0] = 1'b1;
        wclk(3);
        check("overrun cleared", 32'(ovr[0]), 0);
        check("overrun valid cleared", 32'(vld[0]), 0);

        // Reset during data bit 3 of 0x3C, then line held low through and after reset
        rx[0] = 1'b0;               wclk(BIT_T);
        rx[0] = 1'b0;               wclk(BIT_T);
        rx[0] = 1'b0;               wclk(BIT_T);
        rx[0] = 1'b1;               wclk(BIT_T);
        rx[0] = 1'b1;               wclk(BIT_T / 2);
        check("mid-frame busy", 32'(busy[0]), 1);
        reset = 1'b0;
        rx[0] = 1'b0;
        wclk(5);
        check("in reset outputs", 32'({vld[0], ovr[0], busy[0], dout[0]}), 0);
        reset = 1'b1;
        wclk(300);
        check("held low no start", 32'(busy[0]), 0);
        rx[0] = 1'b1;
        wclk(200);
        send(0, 8'h3C, 1'b0, 1'b1, 1'b1, 300);
        check("after reset data", 32'(last_d[0]), 32'h3C);

        // Randomized frames on all three receivers in parallel
        fork
            rand_run(0, 10);
            rand_run(1, 10);
            rand_run(2, 10);
        join
        wclk(20);
        for (int u = 0; u < 3; u++) begin
            check($sformatf("u%0d words outstanding", u), 32'(q[u].size()), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
